// File: rtl/lsu_pkg.sv
// Shared constants and types for the load-store unit.
//   OPC_*   : RV32 major opcodes that need a data-memory access
//   F3_*    : funct3 size/sign encodings for loads and stores
//   state_t : LSU control state
package lsu_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for the load-store unit (purely combinational).
//   funct3 : access size / signedness
//   a      : low two address bits
//   src2   : raw store data      -> wdata (lane-replicated), wmask
//   rdata  : raw memory read word -> ldata (extracted, extended)
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  a,
   input  logic [31:0] src2,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wmask,
   output logic [31:0] ldata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Misaligned halfwords use a[1] only; misaligned words ignore a.
   assign byte_sel = rdata[{a, 3'b000} +: 8];
   assign half_sel = a[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      wdata = src2;
      wmask = 4'b1111;
      case (funct3)
         F3_B: begin
            wdata = {4{src2[7:0]}};
            wmask = 4'b0001 << a;
         end
         F3_H: begin
            wdata = {2{src2[15:0]}};
            wmask = a[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      ldata = rdata;
      case (funct3)
         F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ldata = {24'h0, byte_sel};
         F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ldata = {16'h0, half_sel};
         default: ldata = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load-store unit between execute and write-back.
//   i_valid/o_ready      : accept one instruction + payload from execute
//   o_mem_* / i_mem_*    : data-memory request (held until gnt) and response
//   o_valid/i_ready      : registered payload + formatted load data to write-back
// Non-memory instructions go IDLE -> DONE (one cycle); loads/stores go
// IDLE -> REQ -> WAIT -> DONE.
module lsu
   import lsu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_src1,
   input  logic [31:0] i_ALUout,
   input  logic [31:0] i_src2,
   input  logic        i_reg_wena,
   input  logic [1:0]  i_reg_sel,
   output logic        o_mem_req,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wmask,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_mem_rdata,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic [31:0] o_imm,
   output logic [31:0] o_src1,
   output logic [31:0] o_ALUout,
   output logic        o_reg_wena,
   output logic [1:0]  o_reg_sel
);

   state_t      state, next;
   logic [31:0] src2;
   logic        is_load, is_store, in_mem;
   logic [31:0] wdata, ldata;
   logic [3:0]  wmask;

   assign is_load  = (o_inst[6:0] == OPC_LOAD);
   assign is_store = (o_inst[6:0] == OPC_STORE);
   assign in_mem   = (i_inst[6:0] == OPC_LOAD) || (i_inst[6:0] == OPC_STORE);

   lsu_align u_align (
      .funct3 (o_inst[14:12]),
      .a      (o_ALUout[1:0]),
      .src2   (src2),
      .rdata  (i_mem_rdata),
      .wdata  (wdata),
      .wmask  (wmask),
      .ldata  (ldata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_inst      <= '0;
         o_pc        <= '0;
         o_imm       <= '0;
         o_src1      <= '0;
         o_ALUout    <= '0;
         src2        <= '0;
         o_reg_wena  <= 1'b0;
         o_reg_sel   <= '0;
         o_mem_rdata <= '0;
      end else begin
         state <= next;
         if (state == IDLE && i_valid) begin
            o_inst      <= i_inst;
            o_pc        <= i_pc;
            o_imm       <= i_imm;
            o_src1      <= i_src1;
            o_ALUout    <= i_ALUout;
            src2        <= i_src2;
            o_reg_wena  <= i_reg_wena;
            o_reg_sel   <= i_reg_sel;
            o_mem_rdata <= '0;
         end
         // Store responses carry no data; only loads capture the word.
         if (state == WAIT && i_mem_rvalid && is_load)
            o_mem_rdata <= ldata;
      end
   end

   always_comb begin
      next        = state;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      o_mem_req   = 1'b0;
      o_mem_wen   = is_store;
      o_mem_addr  = {o_ALUout[31:2], 2'b00};
      o_mem_wdata = wdata;
      o_mem_wmask = is_store ? wmask : 4'b0000;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) next = in_mem ? REQ : DONE;
         end
         REQ: begin
            o_mem_req = 1'b1;
            if (i_mem_gnt) next = WAIT;
         end
         WAIT: if (i_mem_rvalid) next = DONE;
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
   import lsu_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_inst = '0, i_pc = '0, i_imm = '0, i_src1 = '0, i_ALUout = '0, i_src2 = '0;
   logic        i_reg_wena = 1'b0;
   logic [1:0]  i_reg_sel = '0;
   logic        o_mem_req, o_mem_wen;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_wmask;
   logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
   logic [31:0] i_mem_rdata = '0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_mem_rdata, o_inst, o_pc, o_imm, o_src1, o_ALUout;
   logic        o_reg_wena;
   logic [1:0]  o_reg_sel;

   int total = 0;
   int bad = 0;

   always #5 i_clk = ~i_clk;

   lsu dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_inst(i_inst), .i_pc(i_pc), .i_imm(i_imm), .i_src1(i_src1),
      .i_ALUout(i_ALUout), .i_src2(i_src2), .i_reg_wena(i_reg_wena), .i_reg_sel(i_reg_sel),
      .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_valid(o_valid),
      .i_ready(i_ready), .o_mem_rdata(o_mem_rdata), .o_inst(o_inst), .o_pc(o_pc),
      .o_imm(o_imm), .o_src1(o_src1), .o_ALUout(o_ALUout), .o_reg_wena(o_reg_wena),
      .o_reg_sel(o_reg_sel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference formatting, straight from the byte/halfword rules.
   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rd);
      logic [31:0] a, bv, hv;
      a  = addr % 4;
      bv = (rd >> (8 * a)) & 32'hFF;
      hv = (rd >> (16 * (a / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
         3'd4:    return bv;
         3'd1:    return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
         3'd5:    return hv;
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] s);
      case (f3)
         3'd0:    return (s & 32'hFF) * 32'h0101_0101;
         3'd1:    return (s & 32'hFFFF) * 32'h0001_0001;
         default: return s;
      endcase
   endfunction

   function automatic logic [3:0] m_wmask(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] a;
      a = addr % 4;
      case (f3)
         3'd0:    return 4'(1 << a);
         3'd1:    return (a >= 2) ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   task automatic run_txn(input string nm, input logic [31:0] inst, input logic [31:0] alu,
                          input logic [31:0] src2, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly, input int rdy_dly);
      logic [31:0] pc, imm, src1, exp_rd;
      logic        wena, is_ld, is_st;
      logic [1:0]  sel;
      pc = $urandom; imm = $urandom; src1 = $urandom;
      wena = 1'($urandom); sel = 2'($urandom);
      is_ld = (inst[6:0] == 7'b0000011);
      is_st = (inst[6:0] == 7'b0100011);
      exp_rd = is_ld ? m_load(inst[14:12], alu, rdata) : 32'h0;

      chk({nm, ".ready_idle"}, o_ready, 1);
      i_valid = 1'b1; i_inst = inst; i_pc = pc; i_imm = imm; i_src1 = src1;
      i_ALUout = alu; i_src2 = src2; i_reg_wena = wena; i_reg_sel = sel;
      @(negedge i_clk);
      i_valid = 1'b0; i_inst = $urandom; i_pc = $urandom; i_ALUout = $urandom; i_src2 = $urandom;

      if (is_ld || is_st) begin
         for (int k = 0; k <= gnt_dly; k++) begin
            chk({nm, ".req"}, o_mem_req, 1);
            chk({nm, ".addr"}, o_mem_addr, {alu[31:2], 2'b00});
            chk({nm, ".wen"}, o_mem_wen, is_st);
            chk({nm, ".wmask"}, o_mem_wmask, is_st ? m_wmask(inst[14:12], alu) : 4'h0);
            if (is_st) chk({nm, ".wdata"}, o_mem_wdata, m_wdata(inst[14:12], src2));
            chk({nm, ".ready_req"}, o_ready, 0);
            chk({nm, ".valid_req"}, o_valid, 0);
            i_mem_gnt = (k == gnt_dly);
            @(negedge i_clk);
         end
         i_mem_gnt = 1'b0;
         for (int k = 0; k <= rv_dly; k++) begin
            chk({nm, ".req_wait"}, o_mem_req, 0);
            chk({nm, ".valid_wait"}, o_valid, 0);
            chk({nm, ".ready_wait"}, o_ready, 0);
            i_mem_rvalid = (k == rv_dly);
            i_mem_rdata  = (k == rv_dly) ? rdata : $urandom;
            @(negedge i_clk);
         end
         i_mem_rvalid = 1'b0;
         i_mem_rdata  = $urandom;
      end

      for (int k = 0; k <= rdy_dly; k++) begin
         chk({nm, ".valid"}, o_valid, 1);
         chk({nm, ".ready_done"}, o_ready, 0);
         chk({nm, ".req_done"}, o_mem_req, 0);
         chk({nm, ".inst"}, o_inst, inst);
         chk({nm, ".pc"}, o_pc, pc);
         chk({nm, ".imm"}, o_imm, imm);
         chk({nm, ".src1"}, o_src1, src1);
         chk({nm, ".alu"}, o_ALUout, alu);
         chk({nm, ".wena"}, o_reg_wena, wena);
         chk({nm, ".sel"}, o_reg_sel, sel);
         chk({nm, ".rdata"}, o_mem_rdata, exp_rd);
         i_ready = (k == rdy_dly);
         @(negedge i_clk);
      end
      i_ready = 1'b0;
      chk({nm, ".valid_after"}, o_valid, 0);
      chk({nm, ".ready_after"}, o_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] inst;
      int kind;

      #1;
      chk("rst.ready", o_ready, 1);
      chk("rst.valid", o_valid, 0);
      chk("rst.req", o_mem_req, 0);
      chk("rst.wmask", o_mem_wmask, 0);
      chk("rst.inst", o_inst, 0);
      chk("rst.rdata", o_mem_rdata, 0);
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      run_txn("add", 32'h00B5_0533, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 0);
      run_txn("lb", 32'h0005_0583, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
      run_txn("lbu", 32'h0005_4583, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
      run_txn("sh", 32'h00B5_1023, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 0);
      run_txn("bp", 32'h00B5_1023, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 2, 4);

      // Reset while waiting for the response, followed by a stale response.
      i_valid = 1'b1; i_inst = 32'h0005_2583; i_ALUout = 32'h0000_4000;
      @(negedge i_clk);
      i_valid = 1'b0; i_mem_gnt = 1'b1;
      @(negedge i_clk);
      i_mem_gnt = 1'b0;
      i_rst_n = 1'b0;
      #1;
      chk("rstw.ready", o_ready, 1);
      chk("rstw.valid", o_valid, 0);
      chk("rstw.req", o_mem_req, 0);
      chk("rstw.inst", o_inst, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_2222;
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      chk("stale.valid", o_valid, 0);
      chk("stale.ready", o_ready, 1);
      chk("stale.rdata", o_mem_rdata, 0);
      run_txn("lw", 32'h0005_2583, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);

      for (int n = 0; n < 60; n++) begin
         inst = $urandom;
         kind = $urandom_range(0, 2);
         if (kind == 1) inst[6:0] = 7'b0000011;
         else if (kind == 2) begin
            inst[6:0]   = 7'b0100011;
            inst[14:12] = 3'($urandom_range(0, 2));
         end else if (inst[6:0] == 7'b0000011 || inst[6:0] == 7'b0100011)
            inst[6:0] = 7'b0010011;
         run_txn("rnd", inst, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         // Idle gap with a possible stray response, which must be ignored.
         i_mem_rvalid = 1'($urandom);
         @(negedge i_clk);
         i_mem_rvalid = 1'b0;
         chk("gap.valid", o_valid, 0);
         chk("gap.ready", o_ready, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load-store unit of the multi-cycle core, sitting between the execute stage and the write-back stage. It accepts one instruction from the execute stage over a valid/ready handshake and runs the data-memory access for loads and stores. It formats store byte lanes and sign/zero-extends load data. It then presents the instruction's payload, plus the formatted read data, to the write-back stage over a second valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

## Interface
- Parameters: none.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  execute stage offers an instruction.
- o_ready  out  1  LSU can accept; equals (state==IDLE).
- i_inst, i_pc, i_imm, i_src1  in  32 each  instruction payload, forwarded unchanged.
- i_ALUout  in  32  ALU result; the effective address for loads and stores.
- i_src2  in  32  store data.
- i_reg_wena  in  1  forwarded register write enable.
- i_reg_sel  in  2  forwarded register-input mux select.
- o_mem_req  out  1  memory request; held until granted.
- o_mem_wen  out  1  1 = store, 0 = load.
- o_mem_addr  out  32  {addr[31:2], 2'b00}.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_wmask  out  4  byte write mask; 0 for loads.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  response; one pulse per granted request, loads and stores alike.
- i_mem_rdata  in  32  raw read word.
- o_valid  out  1  payload valid to the write-back stage.
- i_ready  in  1  write-back stage accepts.
- o_mem_rdata  out  32  extracted and extended load data.
- o_inst, o_pc, o_imm, o_src1, o_ALUout  out  32 each  registered payload.
- o_reg_wena  out  1  registered payload.
- o_reg_sel  out  2  registered payload.

## Operation
- States and transitions:
  - IDLE: o_ready=1. On i_valid, register all payload fields, then:
    - opcode 0000011 (load) or 0100011 (store) -> REQ;
    - any other opcode -> DONE.
  - REQ: o_mem_req=1, with address, wen, wdata and mask driven from registers. On i_mem_gnt -> WAIT.
  - WAIT: on i_mem_rvalid -> DONE. For a load, register the formatted read data; for a store, ignore i_mem_rdata.
  - DONE: o_valid=1. On i_ready -> IDLE.
- Store formatting, using funct3=inst[14:12] and a=addr[1:0]:
  - sb (000): wdata={4{src2[7:0]}}, wmask=0001<<a.
  - sh (001): wdata={2{src2[15:0]}}, wmask=0011<<{a[1],0}.
  - sw (010): wdata=src2, wmask=1111.
- Load formatting:
  - Shift: w=rdata>>(8*a).
  - lb (000) sign-extends w[7:0]; lbu (100) zero-extends w[7:0].
  - lh (001) sign-extends w[15:0]; lhu (101) zero-extends w[15:0].
  - lw (010) and any other funct3: rdata unshifted.
- Misaligned accesses do not trap:
  - halfword uses a[1] only;
  - word ignores a.
- Non-load instructions: o_mem_rdata = 0.

## Timing
- Reset: state=IDLE; o_valid=0; o_mem_req=0; o_mem_wmask=0; all registered outputs 0. o_ready=1 during and after reset.
- Latency counts from the accept cycle T:
  - non-memory instruction: o_valid at T+1;
  - memory instruction with zero-wait memory (gnt in T+1, rvalid in T+2): o_valid at T+3.
- i_mem_rvalid never coincides with its own i_mem_gnt; the earliest response is the cycle after grant.
- All o_mem_* outputs are stable while o_mem_req=1 and not granted.
- DONE with i_ready=0: o_valid and every payload output hold.
- DONE with i_ready=1: returns to IDLE. No new instruction is accepted in that same cycle (o_ready=0 in DONE).
- i_mem_rvalid outside WAIT is ignored, e.g. a stale response after reset.
- Reset in REQ/WAIT/DONE abandons the transaction immediately; nothing is replayed.

## Structure
- Package lsu_pkg holds:
  - opcode constants OPC_LOAD and OPC_STORE;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the 2-bit state enum IDLE, REQ, WAIT, DONE.
- One combinational sub-module, lsu_align, computes store wdata/wmask and load extraction/extension from funct3, a and the raw data. The FSM and payload registers live in lsu.

## Test plan
- Pass-through: add (inst 0x00B50533), i_ready=1 -> o_valid at T+1; o_inst=0x00B50533; no o_mem_req; o_mem_rdata=0.
- lb at addr 0x1003, rdata 0x80FF_FF7F -> o_mem_addr=0x1000, wmask=0, o_mem_rdata=0xFFFF_FF80. The same access as lbu -> 0x0000_0080.
- sh at addr 0x2002, src2=0x1234_ABCD -> wdata=0xABCD_ABCD, wmask=1100, wen=1; o_valid follows rvalid by 1 cycle.
- Back-pressure: gnt delayed 3 cycles, then i_ready low 4 cycles in DONE -> request outputs stable throughout, o_valid and payload held, o_ready=0 until the cycle after i_ready=1.
- Reset asserted in WAIT, then late rvalid -> o_valid stays 0, state IDLE, o_ready=1; the next lw at 0x3000 with rdata 0xDEADBEEF returns 0xDEADBEEF.
